// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// fills the IF/ID register. Boots from ROM word 0 (or RESET_PC), handles
// stall, branch redirect with flush, and 8-bit PC wrap-around.
// Optional interrupt vectoring through ROM word 1 is enabled by defining
// the macro FETCH_INTR_EN (adds i_intr_req, i_rti, o_intr_ack, o_epc).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_BOOT | single cycle after reset: load PC from boot vector, IF/ID bubble
// S_RUN  | normal fetch; branch > stall > rti > interrupt > sequential fetch

module fetch_stage #(
    parameter logic [7:0] NOP_INSTR   = 8'h00,
    parameter bit         BOOT_VECTOR = 1'b1,
    parameter logic [7:0] RESET_PC    = 8'h02
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_stall,
    input  logic       i_branch_taken,
    input  logic [7:0] i_branch_target,
    input  logic [7:0] i_imem_instr,
    input  logic [7:0] i_imem_word0,
    input  logic [7:0] i_imem_word1,
`ifdef FETCH_INTR_EN
    input  logic       i_intr_req,
    input  logic       i_rti,
    output logic       o_intr_ack,
    output logic [7:0] o_epc,
`endif
    output logic [7:0] o_imem_addr,
    output logic [7:0] o_if_instr,
    output logic [7:0] o_if_pc,
    output logic [7:0] o_if_pc_plus1,
    output logic       o_if_valid
);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Per-cycle action selected by the FSM output decode
    typedef enum logic [2:0] {
        A_HOLD   = 3'd0,
        A_BOOT   = 3'd1,
        A_BRANCH = 3'd2,
        A_FETCH  = 3'd3,
        A_INTR   = 3'd4,
        A_RTI    = 3'd5
    } act_t;

    state_t     r_state;
    state_t     w_state_next;
    act_t       w_act;

    logic [7:0] r_pc;
    logic [7:0] r_if_instr;
    logic [7:0] r_if_pc;
    logic [7:0] r_if_pc_plus1;
    logic       r_if_valid;
    logic [7:0] w_pc_plus1;
    logic [7:0] w_boot_pc;

`ifdef FETCH_INTR_EN
    logic [7:0] r_epc;
    logic       r_intr_mask;
    logic       r_intr_ack;
`else
    // Interrupt vector is only consumed when vectoring is built in
    logic       w_unused_word1;
    assign w_unused_word1 = &{1'b0, i_imem_word1};
`endif

    assign w_pc_plus1 = r_pc + 8'd1;
    assign w_boot_pc  = BOOT_VECTOR ? i_imem_word0 : RESET_PC;

    // State register: reset always returns to BOOT
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: BOOT lasts exactly one cycle, RUN is sticky until reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BOOT:  w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_BOOT;
        endcase
    end

    // Output decode: pick this cycle's datapath action by priority
    always_comb begin
        w_act = A_HOLD;
        case (r_state)
            S_BOOT: w_act = A_BOOT;
            S_RUN: begin
                if (i_branch_taken) begin
                    w_act = A_BRANCH;
                end else if (i_stall) begin
                    w_act = A_HOLD;
`ifdef FETCH_INTR_EN
                end else if (i_rti) begin
                    w_act = A_RTI;
                end else if (i_intr_req && !r_intr_mask) begin
                    w_act = A_INTR;
`endif
                end else begin
                    w_act = A_FETCH;
                end
            end
            default: w_act = A_HOLD;
        endcase
    end

    // PC and IF/ID register; bubbles keep the previous if_pc/if_pc_plus1
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= 8'h00;
            r_if_instr    <= NOP_INSTR;
            r_if_pc       <= 8'h00;
            r_if_pc_plus1 <= 8'h00;
            r_if_valid    <= 1'b0;
        end else begin
            case (w_act)
                A_BOOT: begin
                    r_pc       <= w_boot_pc;
                    r_if_instr <= NOP_INSTR;
                    r_if_valid <= 1'b0;
                end
                A_BRANCH: begin
                    r_pc       <= i_branch_target;
                    r_if_instr <= NOP_INSTR;
                    r_if_valid <= 1'b0;
                end
                A_FETCH: begin
                    r_pc          <= w_pc_plus1;
                    r_if_instr    <= i_imem_instr;
                    r_if_pc       <= r_pc;
                    r_if_pc_plus1 <= w_pc_plus1;
                    r_if_valid    <= 1'b1;
                end
`ifdef FETCH_INTR_EN
                A_INTR: begin
                    r_pc       <= i_imem_word1;
                    r_if_instr <= NOP_INSTR;
                    r_if_valid <= 1'b0;
                end
                A_RTI: begin
                    r_pc       <= r_epc;
                    r_if_instr <= NOP_INSTR;
                    r_if_valid <= 1'b0;
                end
`endif
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

`ifdef FETCH_INTR_EN
    // Interrupt bookkeeping: saved PC, nesting mask, one-cycle acknowledge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_epc       <= 8'h00;
            r_intr_mask <= 1'b0;
            r_intr_ack  <= 1'b0;
        end else begin
            r_intr_ack <= (w_act == A_INTR);
            if (w_act == A_INTR) begin
                r_epc       <= r_pc;
                r_intr_mask <= 1'b1;
            end else if (w_act == A_RTI) begin
                r_intr_mask <= 1'b0;
            end
        end
    end

    assign o_intr_ack = r_intr_ack;
    assign o_epc      = r_epc;
`endif

    assign o_imem_addr   = r_pc;
    assign o_if_instr    = r_if_instr;
    assign o_if_pc       = r_if_pc;
    assign o_if_pc_plus1 = r_if_pc_plus1;
    assign o_if_valid    = r_if_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the fetch rules.
`timescale 1ns/1ps

module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] imem_instr;
    logic [7:0] imem_word0;
    logic [7:0] imem_word1;
    logic [7:0] imem_addr;
    logic [7:0] if_instr;
    logic [7:0] if_pc;
    logic [7:0] if_pc_plus1;
    logic       if_valid;
`ifdef FETCH_INTR_EN
    logic       intr_req;
    logic       rti;
    logic       intr_ack;
    logic [7:0] epc;
`endif

    logic [7:0] rom [256];

    int n_pass  = 0;
    int n_total = 0;

    // behavioural model
    bit         m_boot;
    logic [7:0] m_pc, m_instr, m_ifpc, m_ifpc1, m_epc;
    logic       m_valid, m_mask, m_ack;

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_addr];
    assign imem_word0 = rom[0];
    assign imem_word1 = rom[1];

    fetch_stage dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_imem_instr    (imem_instr),
        .i_imem_word0    (imem_word0),
        .i_imem_word1    (imem_word1),
`ifdef FETCH_INTR_EN
        .i_intr_req      (intr_req),
        .i_rti           (rti),
        .o_intr_ack      (intr_ack),
        .o_epc           (epc),
`endif
        .o_imem_addr     (imem_addr),
        .o_if_instr      (if_instr),
        .o_if_pc         (if_pc),
        .o_if_pc_plus1   (if_pc_plus1),
        .o_if_valid      (if_valid)
    );

    // Advance one clock and apply the fetch rules to the model
    task automatic cycle();
        bit do_rti, do_intr;
        do_rti  = 1'b0;
        do_intr = 1'b0;
`ifdef FETCH_INTR_EN
        do_rti  = rti;
        do_intr = intr_req && !m_mask;
`endif
        @(posedge clk);
        m_ack = 1'b0;
        if (rst) begin
            m_boot = 1'b1; m_pc = 8'h00; m_instr = 8'h00; m_ifpc = 8'h00;
            m_ifpc1 = 8'h00; m_valid = 1'b0; m_epc = 8'h00; m_mask = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_pc   = rom[0];
        end else if (branch_taken) begin
            m_pc = branch_target; m_instr = 8'h00; m_valid = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (do_rti) begin
            m_pc = m_epc; m_mask = 1'b0; m_instr = 8'h00; m_valid = 1'b0;
        end else if (do_intr) begin
            m_epc = m_pc; m_pc = rom[1]; m_mask = 1'b1; m_ack = 1'b1;
            m_instr = 8'h00; m_valid = 1'b0;
        end else begin
            m_instr = rom[m_pc];
            m_ifpc  = m_pc;
            m_ifpc1 = 8'((m_pc + 1) % 256);
            m_valid = 1'b1;
            m_pc    = 8'((m_pc + 1) % 256);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        n_total++;
        if ({imem_addr, if_instr, if_pc, if_pc_plus1, if_valid} !== {8'h00, 8'h00, 8'h00, 8'h00, 1'b0})
            $display("FAIL reset_outputs got %h/%h/%h/%h/%b want 00/00/00/00/0",
                     imem_addr, if_instr, if_pc, if_pc_plus1, if_valid);
        else n_pass++;
`ifdef FETCH_INTR_EN
        n_total++;
        if ({intr_ack, epc} !== 9'h000) $display("FAIL reset_intr got ack=%b epc=%h want 0/00", intr_ack, epc);
        else n_pass++;
`endif
        rst = 1'b0;
        cycle();
        n_total++;
        if (imem_addr !== 8'h10 || if_valid !== 1'b0)
            $display("FAIL boot_pc got addr=%h valid=%b want 10/0", imem_addr, if_valid);
        else n_pass++;
        cycle();
        n_total++;
        if (if_pc !== 8'h10 || if_valid !== 1'b1 || if_instr !== rom[8'h10] || if_pc_plus1 !== 8'h11)
            $display("FAIL boot_first_fetch got pc=%h v=%b instr=%h p1=%h want 10/1/%h/11",
                     if_pc, if_valid, if_instr, if_pc_plus1, rom[8'h10]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [3];
        logic [7:0] exp_p1 [3];
        exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00;
        exp_p1[0] = 8'hFF; exp_p1[1] = 8'h00; exp_p1[2] = 8'h01;
        branch_taken = 1'b1; branch_target = 8'hFE;
        cycle();
        branch_taken = 1'b0;
        n_total++;
        if (imem_addr !== 8'hFE || if_valid !== 1'b0)
            $display("FAIL wrap_redirect got addr=%h valid=%b want FE/0", imem_addr, if_valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_total++;
            if (if_pc !== exp_pc[i] || if_pc_plus1 !== exp_p1[i] || if_valid !== 1'b1)
                $display("FAIL wrap_seq%0d got pc=%h p1=%h v=%b want %h/%h/1",
                         i, if_pc, if_pc_plus1, if_valid, exp_pc[i], exp_p1[i]);
            else n_pass++;
        end
        n_total++;
        if (imem_addr !== 8'h01) $display("FAIL wrap_addr got %h want 01", imem_addr);
        else n_pass++;
    endtask

    task automatic test_stall();
        branch_taken = 1'b1; branch_target = 8'h20;
        cycle();
        branch_taken = 1'b0;
        cycle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_total++;
            if (imem_addr !== 8'h21 || if_pc !== 8'h20 || if_pc_plus1 !== 8'h21 ||
                if_valid !== 1'b1 || if_instr !== rom[8'h20])
                $display("FAIL stall_hold%0d got addr=%h pc=%h p1=%h v=%b instr=%h want 21/20/21/1/%h",
                         i, imem_addr, if_pc, if_pc_plus1, if_valid, if_instr, rom[8'h20]);
            else n_pass++;
        end
        stall = 1'b0;
        cycle();
        n_total++;
        if (if_pc !== 8'h21 || if_instr !== rom[8'h21] || imem_addr !== 8'h22)
            $display("FAIL stall_release got pc=%h instr=%h addr=%h want 21/%h/22",
                     if_pc, if_instr, imem_addr, rom[8'h21]);
        else n_pass++;
    endtask

    task automatic test_branch_stall();
        branch_taken = 1'b1; branch_target = 8'h40; stall = 1'b1;
        cycle();
        branch_taken = 1'b0; stall = 1'b0;
        n_total++;
        if (if_valid !== 1'b0 || if_instr !== 8'h00 || imem_addr !== 8'h40 || if_pc !== 8'h21)
            $display("FAIL branch_flush got v=%b instr=%h addr=%h pc=%h want 0/00/40/21",
                     if_valid, if_instr, imem_addr, if_pc);
        else n_pass++;
        cycle();
        n_total++;
        if (if_pc !== 8'h40 || if_valid !== 1'b1 || if_instr !== rom[8'h40])
            $display("FAIL branch_target got pc=%h v=%b instr=%h want 40/1/%h",
                     if_pc, if_valid, if_instr, rom[8'h40]);
        else n_pass++;
    endtask

`ifdef FETCH_INTR_EN
    task automatic test_interrupt();
        branch_taken = 1'b1; branch_target = 8'h33;
        cycle();
        branch_taken = 1'b0; intr_req = 1'b1;
        cycle();
        n_total++;
        if (epc !== 8'h33 || intr_ack !== 1'b1 || imem_addr !== 8'h80 || if_valid !== 1'b0)
            $display("FAIL intr_take got epc=%h ack=%b addr=%h v=%b want 33/1/80/0",
                     epc, intr_ack, imem_addr, if_valid);
        else n_pass++;
        cycle();
        n_total++;
        if (intr_ack !== 1'b0 || imem_addr !== 8'h81 || if_pc !== 8'h80)
            $display("FAIL intr_masked got ack=%b addr=%h pc=%h want 0/81/80", intr_ack, imem_addr, if_pc);
        else n_pass++;
        intr_req = 1'b0; rti = 1'b1;
        cycle();
        rti = 1'b0;
        n_total++;
        if (imem_addr !== 8'h33 || if_valid !== 1'b0)
            $display("FAIL intr_rti got addr=%h v=%b want 33/0", imem_addr, if_valid);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        stall = 1'b1; rst = 1'b1;
`ifdef FETCH_INTR_EN
        intr_req = 1'b1;
`endif
        cycle();
        rst = 1'b0;
        n_total++;
        if ({imem_addr, if_instr, if_pc, if_pc_plus1, if_valid} !== {8'h00, 8'h00, 8'h00, 8'h00, 1'b0})
            $display("FAIL midreset_outputs got %h/%h/%h/%h/%b want 00/00/00/00/0",
                     imem_addr, if_instr, if_pc, if_pc_plus1, if_valid);
        else n_pass++;
        cycle();
        n_total++;
        if (imem_addr !== 8'h10 || if_valid !== 1'b0)
            $display("FAIL midreset_boot got addr=%h v=%b want 10/0", imem_addr, if_valid);
        else n_pass++;
        stall = 1'b0;
`ifdef FETCH_INTR_EN
        intr_req = 1'b0;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(99) < 3);
            stall         = ($urandom_range(99) < 25);
            branch_taken  = ($urandom_range(99) < 12);
            branch_target = 8'($urandom_range(255));
`ifdef FETCH_INTR_EN
            intr_req      = ($urandom_range(99) < 20);
            rti           = ($urandom_range(99) < 8);
`endif
            cycle();
            n_total++;
            if ({imem_addr, if_instr, if_pc, if_pc_plus1, if_valid} !==
                {m_pc, m_instr, m_ifpc, m_ifpc1, m_valid})
                $display("FAIL random_cycle%0d got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", i,
                         imem_addr, if_instr, if_pc, if_pc_plus1, if_valid,
                         m_pc, m_instr, m_ifpc, m_ifpc1, m_valid);
            else n_pass++;
`ifdef FETCH_INTR_EN
            n_total++;
            if ({intr_ack, epc} !== {m_ack, m_epc})
                $display("FAIL random_intr%0d got ack=%b epc=%h want %b/%h", i, intr_ack, epc, m_ack, m_epc);
            else n_pass++;
`endif
        end
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
`ifdef FETCH_INTR_EN
        intr_req = 1'b0; rti = 1'b0;
`endif
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom_range(255));
        rom[0] = 8'h10;
        rom[1] = 8'h80;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
`ifdef FETCH_INTR_EN
        intr_req = 1'b0; rti = 1'b0;
`endif
        m_boot = 1'b1; m_pc = 8'h00; m_instr = 8'h00; m_ifpc = 8'h00; m_ifpc1 = 8'h00;
        m_valid = 1'b0; m_epc = 8'h00; m_mask = 1'b0; m_ack = 1'b0;

        test_reset();
        test_wrap();
        test_stall();
        test_branch_stall();
`ifdef FETCH_INTR_EN
        test_interrupt();
`endif
        test_reset_mid();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
